// File: rtl/timer_sched_if.sv
// Request and timer-register bus bundle for timer_sched.
// The master modport is the scheduler's view; slave is the requester/timer side.
interface timer_sched_if #(
  parameter int AW = 9,
  parameter int N  = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          req_valid_i;
  logic          req_ready_o;
  logic [IW-1:0] req_id_i;
  logic [63:0]   req_deadline_i;
  logic          reg_we_o;
  logic          reg_re_o;
  logic [AW-1:0] reg_addr_o;
  logic [31:0]   reg_wdata_o;
  logic [3:0]    reg_be_o;
  logic          reg_error_i;

  modport master (
    input  req_valid_i, req_id_i, req_deadline_i, reg_error_i,
    output req_ready_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, reg_be_o
  );

  modport slave (
    output req_valid_i, req_id_i, req_deadline_i, reg_error_i,
    input  req_ready_o, reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, reg_be_o
  );
endinterface

// File: rtl/timer_sched.sv
// Deadline scheduler: keeps the timer compare register at the earliest pending deadline.
// Optional per-channel cancel input is enabled by defining TIMER_SCHED_CANCEL_EN.
module timer_sched #(
  parameter int          AW        = 9,
  parameter int          N         = 4,
  parameter logic [11:0] PRESCALE  = 12'd0,
  parameter logic [7:0]  STEP      = 8'd1,
  parameter logic [31:0] A_CTRL    = 32'h0000_0004,
  parameter logic [31:0] A_INTR_EN = 32'h0000_0100,
  parameter logic [31:0] A_CFG0    = 32'h0000_010C,
  parameter logic [31:0] A_CMP_LO  = 32'h0000_0118,
  parameter logic [31:0] A_CMP_HI  = 32'h0000_011C
) (
  input  logic          clk_i,
  input  logic          rst_i,
  timer_sched_if.master bus,
  input  logic          intr_timer_i,
`ifdef TIMER_SCHED_CANCEL_EN
  input  logic [N-1:0]  cancel_i,
`endif
  output logic [N-1:0]  fire_o,
  output logic [N-1:0]  pending_o,
  output logic          busy_o,
  output logic          err_o
);
  localparam int          IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    S_INIT0, S_INIT1, S_INIT2, S_IDLE, S_SEL, S_WR_HI_MAX, S_WR_LO, S_WR_HI
  } state_t;

  state_t        r_state;
  logic          r_init_arm;
  logic [N-1:0]  r_pending;
  logic [63:0]   r_deadline [N];
  logic          r_dirty;
  logic [63:0]   r_target;
  logic          r_err;
  logic [N-1:0]  r_fire;
  logic          r_busy;
  logic          r_ready;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;

  logic          w_accept;
  logic          w_intr_take;
  logic [N-1:0]  w_req_hit;
  logic [N-1:0]  w_fire_mask;
  logic [N-1:0]  w_cancel;
  logic [63:0]   w_min;

`ifdef TIMER_SCHED_CANCEL_EN
  assign w_cancel = cancel_i;
`else
  assign w_cancel = {N{1'b0}};
`endif

  assign w_accept    = bus.req_valid_i & r_ready;
  assign w_intr_take = (r_state == S_IDLE) && intr_timer_i && (r_target != ALL1);

  // Earliest pending deadline; strict compare keeps the lowest id on ties.
  always_comb begin
    w_min = ALL1;
    for (int i = 0; i < N; i++) begin
      if (r_pending[i] && (r_deadline[i] < w_min)) begin
        w_min = r_deadline[i];
      end else begin
        w_min = w_min;
      end
    end
  end

  // Per-channel request decode and expiry match against the armed target.
  always_comb begin
    w_req_hit   = {N{1'b0}};
    w_fire_mask = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_req_hit[i]   = w_accept && (bus.req_id_i == IW'(i));
      w_fire_mask[i] = w_intr_take && r_pending[i] && (r_deadline[i] <= r_target);
    end
  end

  // Channel storage; a new request on a channel beats its fire or cancel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= {N{1'b0}};
      for (int i = 0; i < N; i++) r_deadline[i] <= 64'd0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_req_hit[i]) begin
          r_pending[i]  <= 1'b1;
          r_deadline[i] <= bus.req_deadline_i;
        end else if (w_fire_mask[i] || w_cancel[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Control FSM; register-bus outputs are launched for the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_INIT0;
      r_init_arm <= 1'b0;
      r_dirty    <= 1'b0;
      r_target   <= ALL1;
      r_err      <= 1'b0;
      r_fire     <= {N{1'b0}};
      r_busy     <= 1'b1;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= {AW{1'b0}};
      r_wdata    <= 32'd0;
      r_be       <= 4'h0;
    end else begin
      r_we    <= 1'b0;
      r_addr  <= {AW{1'b0}};
      r_wdata <= 32'd0;
      r_be    <= 4'h0;
      r_fire  <= w_fire_mask;
      r_busy  <= 1'b1;
      r_ready <= 1'b1;
      r_err   <= r_err | (r_we & bus.reg_error_i);
      r_dirty <= r_dirty | w_accept | (|w_fire_mask) | (|w_cancel);
      case (r_state)
        S_INIT0: begin
          r_ready <= 1'b0;
          r_we    <= 1'b1;
          r_be    <= 4'hF;
          // First cycle out of reset only arms the CFG0 write so it shows in INIT0.
          if (!r_init_arm) begin
            r_init_arm <= 1'b1;
            r_addr     <= AW'(A_CFG0);
            r_wdata    <= {8'h00, STEP, 4'b0000, PRESCALE};
          end else begin
            r_addr  <= AW'(A_INTR_EN);
            r_wdata <= 32'd1;
            r_state <= S_INIT1;
          end
        end
        S_INIT1: begin
          r_ready <= 1'b0;
          r_we    <= 1'b1;
          r_be    <= 4'hF;
          r_addr  <= AW'(A_CTRL);
          r_wdata <= 32'd1;
          r_state <= S_INIT2;
        end
        S_INIT2: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_intr_take) begin
            r_busy <= 1'b0;
          end else if (r_dirty || w_accept || (|w_cancel)) begin
            r_dirty <= 1'b0;
            r_state <= S_SEL;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_SEL: begin
          r_target <= w_min;
          r_we     <= 1'b1;
          r_be     <= 4'hF;
          r_addr   <= AW'(A_CMP_HI);
          r_wdata  <= 32'hFFFF_FFFF;
          r_state  <= S_WR_HI_MAX;
        end
        S_WR_HI_MAX: begin
          r_we    <= 1'b1;
          r_be    <= 4'hF;
          r_addr  <= AW'(A_CMP_LO);
          r_wdata <= r_target[31:0];
          r_state <= S_WR_LO;
        end
        S_WR_LO: begin
          r_we    <= 1'b1;
          r_be    <= 4'hF;
          r_addr  <= AW'(A_CMP_HI);
          r_wdata <= r_target[63:32];
          r_state <= S_WR_HI;
        end
        S_WR_HI: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready    <= 1'b0;
          r_init_arm <= 1'b0;
          r_state    <= S_INIT0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.reg_we_o    = r_we;
  assign bus.reg_re_o    = 1'b0;
  assign bus.reg_addr_o  = r_addr;
  assign bus.reg_wdata_o = r_wdata;
  assign bus.reg_be_o    = r_be;
  assign fire_o          = r_fire;
  assign pending_o       = r_pending;
  assign busy_o          = r_busy;
  assign err_o           = r_err;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: init writes, compare sequencing, expiry, errors, reset.
module tb_timer_sched;
  localparam int          N         = 4;
  localparam int          AW        = 9;
  localparam logic [31:0] A_CTRL    = 32'h0000_0004;
  localparam logic [31:0] A_INTR_EN = 32'h0000_0100;
  localparam logic [31:0] A_CFG0    = 32'h0000_010C;
  localparam logic [31:0] A_CMP_LO  = 32'h0000_0118;
  localparam logic [31:0] A_CMP_HI  = 32'h0000_011C;
  localparam logic [63:0] ALL1      = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         intr = 1'b0;
  logic [N-1:0] fire;
  logic [N-1:0] pend;
  logic         busy;
  logic         err;
`ifdef TIMER_SCHED_CANCEL_EN
  logic [N-1:0] cancel = 4'b0000;
`endif

  timer_sched_if #(.AW(AW), .N(N)) bus ();

  timer_sched #(.AW(AW), .N(N)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .intr_timer_i(intr),
`ifdef TIMER_SCHED_CANCEL_EN
    .cancel_i(cancel),
`endif
    .fire_o(fire),
    .pending_o(pend),
    .busy_o(busy),
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
    int            cyc;
  } wr_t;

  typedef struct {
    bit          is_intr;
    logic [1:0]  id;
    logic [63:0] dl;
    logic [3:0]  exp_fire;
    logic [3:0]  exp_pend;
    int          exp_nwr;
    logic [63:0] exp_cmp;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  wr_t        wlog[$];
  logic [3:0] fire_acc;
  int         fire_pulses;
  vec_t       vecs[14];

  task automatic step();
    wr_t w;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.reg_we_o) begin
      w.addr = bus.reg_addr_o;
      w.data = bus.reg_wdata_o;
      w.be   = bus.reg_be_o;
      w.cyc  = cyc;
      wlog.push_back(w);
    end
    fire_acc = fire_acc | fire;
    if (fire != 4'b0000) fire_pulses++;
  endtask

  task automatic clear_mon();
    wlog.delete();
    fire_acc    = 4'b0000;
    fire_pulses = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx < wlog.size()) begin
      chk({nm, "_addr"}, 64'(wlog[idx].addr), 64'(addr[AW-1:0]));
      chk({nm, "_data"}, 64'(wlog[idx].data), 64'(data));
      chk({nm, "_be"}, 64'(wlog[idx].be), 64'h0000_0000_0000_000F);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: write %0d missing, got %0d writes", nm, idx, wlog.size());
    end
  endtask

  task automatic chk_cyc(input string nm, input int idx, input int exp);
    if (idx < wlog.size()) begin
      chk(nm, 64'(wlog[idx].cyc), 64'(exp));
    end else begin
      total++;
      bad++;
      $display("FAIL %s: write %0d missing, got %0d writes", nm, idx, wlog.size());
    end
  endtask

  task automatic chk_cmp_seq(input string nm, input int base, input logic [63:0] cmp);
    chk_wr({nm, "_himax"}, base, A_CMP_HI, 32'hFFFF_FFFF);
    chk_wr({nm, "_lo"}, base + 1, A_CMP_LO, cmp[31:0]);
    chk_wr({nm, "_hi"}, base + 2, A_CMP_HI, cmp[63:32]);
  endtask

  task automatic request(input logic [1:0] id, input logic [63:0] dl);
    bus.req_valid_i    = 1'b1;
    bus.req_id_i       = id;
    bus.req_deadline_i = dl;
  endtask

  task automatic init_check(input string nm);
    int r;
    clear_mon();
    rst = 1'b0;
    r = cyc;
    chk({nm, "_ready_init"}, 64'(bus.req_ready_o), 64'h0);
    chk({nm, "_busy_init"}, 64'(busy), 64'h1);
    repeat (8) step();
    chk({nm, "_nwr"}, 64'(wlog.size()), 64'h3);
    chk_wr({nm, "_cfg0"}, 0, A_CFG0, 32'h0001_0000);
    chk_wr({nm, "_inten"}, 1, A_INTR_EN, 32'h0000_0001);
    chk_wr({nm, "_ctrl"}, 2, A_CTRL, 32'h0000_0001);
    chk_cyc({nm, "_cyc0"}, 0, r + 1);
    chk_cyc({nm, "_cyc1"}, 1, r + 2);
    chk_cyc({nm, "_cyc2"}, 2, r + 3);
    chk({nm, "_busy_done"}, 64'(busy), 64'h0);
    chk({nm, "_ready_done"}, 64'(bus.req_ready_o), 64'h1);
    chk({nm, "_pend"}, 64'(pend), 64'h0);
  endtask

  initial begin
    int c;
    bus.req_valid_i    = 1'b0;
    bus.req_id_i       = 2'd0;
    bus.req_deadline_i = 64'd0;
    bus.reg_error_i    = 1'b0;
    clear_mon();

    // op table; state carried over from the previous row
    vecs[0]  = '{1'b0, 2'd0, 64'd500,                1'b0 ? 4'h0 : 4'b0000, 4'b0101, 3, 64'd500};
    vecs[1]  = '{1'b0, 2'd1, 64'd300,                4'b0000, 4'b0111, 3, 64'd300};
    vecs[2]  = '{1'b1, 2'd0, 64'd0,                  4'b0010, 4'b0101, 3, 64'd500};
    vecs[3]  = '{1'b1, 2'd0, 64'd0,                  4'b0001, 4'b0100, 3, 64'h0000_0001_0000_0100};
    vecs[4]  = '{1'b1, 2'd0, 64'd0,                  4'b0100, 4'b0000, 3, ALL1};
    vecs[5]  = '{1'b1, 2'd0, 64'd0,                  4'b0000, 4'b0000, 0, 64'd0};
    vecs[6]  = '{1'b0, 2'd1, 64'd200,                4'b0000, 4'b0010, 3, 64'd200};
    vecs[7]  = '{1'b0, 2'd3, 64'd200,                4'b0000, 4'b1010, 3, 64'd200};
    vecs[8]  = '{1'b1, 2'd0, 64'd0,                  4'b1010, 4'b0000, 3, ALL1};
    vecs[9]  = '{1'b0, 2'd3, 64'h0000_0002_0000_0000, 4'b0000, 4'b1000, 3, 64'h0000_0002_0000_0000};
    vecs[10] = '{1'b0, 2'd3, 64'h0000_0000_0000_0050, 4'b0000, 4'b1000, 3, 64'h50};
    vecs[11] = '{1'b0, 2'd0, ALL1,                   4'b0000, 4'b1001, 3, 64'h50};
    vecs[12] = '{1'b1, 2'd0, 64'd0,                  4'b1000, 4'b0001, 3, ALL1};
    vecs[13] = '{1'b1, 2'd0, 64'd0,                  4'b0000, 4'b0001, 0, 64'd0};

    // reset values while rst is held
    step();
    step();
    chk("rst_we", 64'(bus.reg_we_o), 64'h0);
    chk("rst_addr", 64'(bus.reg_addr_o), 64'h0);
    chk("rst_wdata", 64'(bus.reg_wdata_o), 64'h0);
    chk("rst_be", 64'(bus.reg_be_o), 64'h0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'h0);
    chk("rst_fire", 64'(fire), 64'h0);
    chk("rst_pend", 64'(pend), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_re", 64'(bus.reg_re_o), 64'h0);
    init_check("init");

    // first request: exact cycle placement of the compare update
    clear_mon();
    c = cyc;
    request(2'd2, 64'h0000_0001_0000_0100);
    step();
    bus.req_valid_i = 1'b0;
    chk("seq_busy_sel", 64'(busy), 64'h1);
    repeat (4) step();
    chk("seq_busy_idle", 64'(busy), 64'h0);
    repeat (3) step();
    chk("seq_nwr", 64'(wlog.size()), 64'h3);
    chk_cmp_seq("seq", 0, 64'h0000_0001_0000_0100);
    chk_cyc("seq_cyc0", 0, c + 2);
    chk_cyc("seq_cyc1", 1, c + 3);
    chk_cyc("seq_cyc2", 2, c + 4);

    for (int i = 0; i < 14; i++) begin
      clear_mon();
      if (vecs[i].is_intr) begin
        intr = 1'b1;
        step();
        intr = 1'b0;
      end else begin
        request(vecs[i].id, vecs[i].dl);
        step();
        bus.req_valid_i = 1'b0;
      end
      repeat (8) step();
      chk($sformatf("v%0d_fire", i), 64'(fire_acc), 64'(vecs[i].exp_fire));
      chk($sformatf("v%0d_pulses", i), 64'(fire_pulses), (vecs[i].exp_fire != 4'b0000) ? 64'h1 : 64'h0);
      chk($sformatf("v%0d_pend", i), 64'(pend), 64'(vecs[i].exp_pend));
      chk($sformatf("v%0d_nwr", i), 64'(wlog.size()), 64'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr == 3) chk_cmp_seq($sformatf("v%0d", i), 0, vecs[i].exp_cmp);
    end

    // request arriving during WR_LO completes the running update first
    clear_mon();
    c = cyc;
    request(2'd0, 64'd900);
    step();
    bus.req_valid_i = 1'b0;
    step();
    step();
    request(2'd0, 64'd100);
    step();
    bus.req_valid_i = 1'b0;
    repeat (8) step();
    chk("late_nwr", 64'(wlog.size()), 64'h6);
    chk_cmp_seq("late_a", 0, 64'd900);
    chk_cmp_seq("late_b", 3, 64'd100);
    chk_cyc("late_cyc3", 3, c + 7);
    chk("late_pend", 64'(pend), 64'h1);

    // register error on the CMP_LO write
    clear_mon();
    c = cyc;
    request(2'd1, 64'd700);
    step();
    bus.req_valid_i = 1'b0;
    step();
    step();
    chk("err_before", 64'(err), 64'h0);
    bus.reg_error_i = 1'b1;
    step();
    bus.reg_error_i = 1'b0;
    chk("err_set", 64'(err), 64'h1);
    chk("err_hi_we", 64'(bus.reg_we_o), 64'h1);
    repeat (6) step();
    chk("err_sticky", 64'(err), 64'h1);
    chk("err_nwr", 64'(wlog.size()), 64'h3);
    chk_cmp_seq("err", 0, 64'd100);
    chk_cyc("err_cyc2", 2, c + 4);

    // request on ch0 in the same cycle ch0 expires: request wins
    clear_mon();
    intr = 1'b1;
    request(2'd0, 64'd50);
    step();
    intr = 1'b0;
    bus.req_valid_i = 1'b0;
    chk("race_fire", 64'(fire), 64'h1);
    chk("race_pend", 64'(pend), 64'h3);
    repeat (7) step();
    chk("race_nwr", 64'(wlog.size()), 64'h3);
    chk_cmp_seq("race", 0, 64'd50);

`ifdef TIMER_SCHED_CANCEL_EN
    clear_mon();
    cancel = 4'b0011;
    step();
    cancel = 4'b0000;
    repeat (7) step();
    chk("cancel_pend", 64'(pend), 64'h0);
    chk_cmp_seq("cancel", 0, ALL1);
    clear_mon();
    cancel = 4'b0010;
    request(2'd1, 64'd123);
    step();
    cancel = 4'b0000;
    bus.req_valid_i = 1'b0;
    repeat (7) step();
    chk("cancel_race_pend", 64'(pend), 64'h2);
    chk_cmp_seq("cancel_race", 0, 64'd123);
`endif

    // reset in the middle of an update abandons it and reruns init
    request(2'd2, 64'd1000);
    step();
    bus.req_valid_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_we", 64'(bus.reg_we_o), 64'h0);
    chk("mid_rst_pend", 64'(pend), 64'h0);
    chk("mid_rst_err", 64'(err), 64'h0);
    chk("mid_rst_ready", 64'(bus.req_ready_o), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h1);
    init_check("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
